// File: rtl/mem_server_l1.sv
// Memory-side responder: word reads/writes on an internal array, responses returned in order
// after a fixed latency through a credit-limited response FIFO.
module mem_server_l1 #(
    parameter int p_opaq_bits = 8,
    parameter int p_mem_words = 256,
    parameter int p_latency   = 2,
    parameter int p_depth     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [31:0]            resp_addr,
    output logic [31:0]            resp_data,
    input  logic                   init_en,
    input  logic [31:0]            init_addr,
    input  logic [31:0]            init_data
);

    localparam int p_idx_bits = $clog2(p_mem_words);
    localparam int cnt_bits   = $clog2(p_depth + 1);
    localparam int ptr_bits   = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [31:0]           mem [p_mem_words];
    logic [cnt_bits-1:0]   count;
    logic                  req_fire;
    logic                  resp_fire;
    logic [p_idx_bits-1:0] req_idx;
    logic [p_idx_bits-1:0] init_idx;
    logic [31:0]           rd_data;

    logic                   enq_val;
    logic                   enq_op;
    logic [p_opaq_bits-1:0] enq_opaque;
    logic [31:0]            enq_addr;
    logic [31:0]            enq_data;

    // Bits outside the word index are intentionally ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:p_idx_bits+2],
                                init_addr[1:0], init_addr[31:p_idx_bits+2]};

    assign req_idx   = req_addr[p_idx_bits+1:2];
    assign init_idx  = init_addr[p_idx_bits+1:2];
    assign req_rdy   = (count < cnt_bits'(p_depth));
    assign req_fire  = req_val & req_rdy;
    assign resp_fire = resp_val & resp_rdy;
    assign rd_data   = req_op ? 32'd0 : mem[req_idx];

    // Backdoor write is issued last so it wins over a same-word request write.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (req_fire && req_op) mem[req_idx] <= req_data;
            if (init_en) mem[init_idx] <= init_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    generate
        if (p_latency > 1) begin : g_pipe
            localparam int stages = p_latency - 1;
            logic                   st_val    [stages];
            logic                   st_op     [stages];
            logic [p_opaq_bits-1:0] st_opaque [stages];
            logic [31:0]            st_addr   [stages];
            logic [31:0]            st_data   [stages];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < stages; i++) st_val[i] <= 1'b0;
                end else begin
                    st_val[0] <= req_fire;
                    for (int i = 1; i < stages; i++) st_val[i] <= st_val[i-1];
                end
                st_op[0]     <= req_op;
                st_opaque[0] <= req_opaque;
                st_addr[0]   <= req_addr;
                st_data[0]   <= rd_data;
                for (int i = 1; i < stages; i++) begin
                    st_op[i]     <= st_op[i-1];
                    st_opaque[i] <= st_opaque[i-1];
                    st_addr[i]   <= st_addr[i-1];
                    st_data[i]   <= st_data[i-1];
                end
            end

            assign enq_val    = st_val[stages-1];
            assign enq_op     = st_op[stages-1];
            assign enq_opaque = st_opaque[stages-1];
            assign enq_addr   = st_addr[stages-1];
            assign enq_data   = st_data[stages-1];
        end else begin : g_direct
            assign enq_val    = req_fire;
            assign enq_op     = req_op;
            assign enq_opaque = req_opaque;
            assign enq_addr   = req_addr;
            assign enq_data   = rd_data;
        end
    endgenerate

    logic                   fifo_op     [p_depth];
    logic [p_opaq_bits-1:0] fifo_opaque [p_depth];
    logic [31:0]            fifo_addr   [p_depth];
    logic [31:0]            fifo_data   [p_depth];
    logic [ptr_bits-1:0]    head;
    logic [ptr_bits-1:0]    tail;
    logic [cnt_bits-1:0]    fifo_cnt;

    // The request credit guarantees a free slot whenever enq_val is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq_val) begin
                fifo_op[tail]     <= enq_op;
                fifo_opaque[tail] <= enq_opaque;
                fifo_addr[tail]   <= enq_addr;
                fifo_data[tail]   <= enq_data;
                tail <= (tail == ptr_bits'(p_depth - 1)) ? '0 : tail + 1'b1;
            end
            if (resp_fire) begin
                head <= (head == ptr_bits'(p_depth - 1)) ? '0 : head + 1'b1;
            end
            case ({enq_val, resp_fire})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign resp_val    = (fifo_cnt != '0);
    assign resp_op     = resp_val ? fifo_op[head]     : 1'b0;
    assign resp_opaque = resp_val ? fifo_opaque[head] : '0;
    assign resp_addr   = resp_val ? fifo_addr[head]   : 32'd0;
    assign resp_data   = resp_val ? fifo_data[head]   : 32'd0;

endmodule

// File: tb/tb_mem_server_l1.sv
// Bench for mem_server_l1: directed scenarios plus random traffic, checked against a
// transaction-level model (word array + in-order expected-response queue with ready times).
module tb_mem_server_l1;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int WORDS = 256;
    localparam int EW    = 1 + 8 + 32 + 32 + 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic        req_op = 1'b0;
    logic [7:0]  req_opaque = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    logic        init_en = 1'b0;
    logic [31:0] init_addr = '0;
    logic [31:0] init_data = '0;

    mem_server_l1 #(.p_opaq_bits(8), .p_mem_words(WORDS), .p_latency(LAT), .p_depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_opaque(req_opaque),
        .req_addr(req_addr), .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_opaque(resp_opaque),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .init_en(init_en), .init_addr(init_addr), .init_data(init_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit checking = 0;
    bit rand_done = 0;

    // Model: word array, outstanding count, expected responses {op, opaque, addr, data, ready_cycle}.
    logic [31:0]   mem_m [WORDS];
    int            mcount = 0;
    logic [EW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [EW-1:0] h;
        bit            exp_val;
        bit            rdy_m;
        int            idx;
        exp_val = 0;
        rdy_m   = (mcount < DEPTH);
        if (checking) begin
            exp_val = (exp_q.size() > 0) && (exp_q[0][31:0] <= 32'(cyc));
            chk("req_rdy", 32'(req_rdy), 32'(rdy_m));
            chk("resp_val", 32'(resp_val), 32'(exp_val));
            if (exp_val) begin
                h = exp_q[0];
                chk("resp_op", 32'(resp_op), 32'(h[104]));
                chk("resp_opaque", 32'(resp_opaque), 32'(h[103:96]));
                chk("resp_addr", resp_addr, h[95:64]);
                chk("resp_data", resp_data, h[63:32]);
            end else begin
                chk("idle_zero", resp_data | resp_addr | 32'(resp_opaque) | 32'(resp_op), 32'd0);
            end
        end
        if (!rst) begin
            exp_q.delete();
            mcount   = 0;
            checking = 1;
        end else if (checking) begin
            if (exp_val && resp_rdy) begin
                void'(exp_q.pop_front());
                mcount--;
            end
            if (req_val && rdy_m) begin
                idx = int'(req_addr[9:2]);
                h = {req_op, req_opaque, req_addr, (req_op ? 32'd0 : mem_m[idx]), 32'(cyc + LAT)};
                exp_q.push_back(h);
                mcount++;
                if (req_op) mem_m[idx] = req_data;
            end
            if (init_en) mem_m[int'(init_addr[9:2])] = init_data;
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                        input logic [31:0] data, output int waits);
        bit got;
        got = 0;
        waits = 0;
        req_val = 1'b1; req_op = op; req_opaque = opq; req_addr = addr; req_data = data;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            got = req_rdy;
            @(posedge clk);
            #1;
            if (got) begin
                waits = n;
                break;
            end
        end
        req_val = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic init_write(input logic [31:0] addr, input logic [31:0] data);
        init_en = 1'b1; init_addr = addr; init_data = data;
        @(posedge clk);
        #1 init_en = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        resp_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        do_reset(3);
        @(negedge clk);
        chk("rst_rdy", 32'(req_rdy), 32'd1);
        chk("rst_resp_val", 32'(resp_val), 32'd0);

        for (int i = 0; i < WORDS; i++) init_write(32'(i * 4), $urandom);

        // Backdoor preload then read.
        init_write(32'h10, 32'hDEADBEEF);
        send(1'b0, 8'h3A, 32'h10, 32'h0, w);
        drain();

        // Write followed immediately by read of the same word.
        send(1'b1, 8'h01, 32'h20, 32'h12345678, w);
        send(1'b0, 8'h02, 32'h20, 32'h0, w);
        drain();

        // Backpressure: four accepted, then credit exhausted.
        resp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 8'(8'h40 + i), 32'(i * 4), 32'h0, w);
        req_val = 1'b1; req_addr = 32'h50;
        repeat (3) begin
            @(negedge clk);
            chk("full_rdy", 32'(req_rdy), 32'd0);
            @(posedge clk);
        end
        #1 req_val = 1'b0;
        fork
            begin
                send(1'b0, 8'h44, 32'h50, 32'h0, w);
                send(1'b0, 8'h45, 32'h54, 32'h0, w);
            end
            begin
                repeat (2) @(posedge clk);
                #1 resp_rdy = 1'b1;
            end
        join
        drain();

        // Streaming at full rate.
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 8'(i), 32'(i * 4 + 32'h80), 32'h0, w);
            chk("stream_wait", 32'(w), 32'd0);
        end
        drain();

        // Aliasing, and backdoor beating a same-word request write.
        send(1'b1, 8'h60, 32'h400, 32'hA5A5A5A5, w);
        send(1'b0, 8'h61, 32'h0, 32'h0, w);
        init_en = 1'b1; init_addr = 32'h0; init_data = 32'hCAFEF00D;
        send(1'b1, 8'h62, 32'h400, 32'h11111111, w);
        init_en = 1'b0;
        send(1'b0, 8'h63, 32'h800, 32'h0, w);
        drain();

        // Reset with requests outstanding.
        resp_rdy = 1'b0;
        send(1'b1, 8'h70, 32'h44, 32'h0BADCAFE, w);
        send(1'b0, 8'h71, 32'h48, 32'h0, w);
        send(1'b0, 8'h72, 32'h4C, 32'h0, w);
        do_reset(1);
        @(negedge clk);
        chk("midrst_resp_val", 32'(resp_val), 32'd0);
        chk("midrst_rdy", 32'(req_rdy), 32'd1);
        resp_rdy = 1'b1;
        send(1'b0, 8'h73, 32'h44, 32'h0, w);
        drain();

        // Random traffic with random response backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 9) == 0)
                        init_write($urandom, $urandom);
                    else
                        send(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 32'h3FF),
                             $urandom, w);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 resp_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_server_l1.md
Name: mem_server_l1

Overview:
- Memory-side responder for the data and instruction memory client ports of the Blimp cores. It accepts requests with a val/rdy handshake, performs word reads and writes on an internal register-file memory, and returns in-order responses after a fixed latency.
- A credit-limited response queue provides backpressure.
- The block is the server end of the memory interface and the standard memory model for top-level processor benches.

Parameters:
- p_opaq_bits, 8: width of the opaque tag echoed from request to response.
- p_mem_words, 256: number of 32-bit words stored; must be a power of 2. p_idx_bits = $clog2(p_mem_words).
- p_latency, 2: cycles from request accept to earliest response; must be ≥ 1.
- p_depth, 4: maximum requests outstanding (in pipeline plus queue); must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst == 0 resets on the rising clk edge).
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_op  in  1  0 = read, 1 = write.
- req_opaque  in  p_opaq_bits  request tag.
- req_addr  in  32  byte address.
- req_data  in  32  write data.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_op  out  1  echoed op.
- resp_opaque  out  p_opaq_bits  echoed tag.
- resp_addr  out  32  echoed address.
- resp_data  out  32  read data; 0 for writes.
- init_en  in  1  backdoor write enable (bench preload).
- init_addr  in  32  backdoor byte address.
- init_data  in  32  backdoor write data.

Behaviour:
- Reset: the cycle after rst == 0, resp_val = 0, req_rdy = 1, outstanding count = 0, pipeline valids cleared, queue emptied. Memory contents are NOT cleared by reset.
- Reset mid-operation: in-flight and queued responses are dropped silently. Writes already accepted remain in memory.
- Handshakes:
  - Fire = val & rdy on a rising edge.
  - req_rdy = (count < p_depth), driven from registered state only. It has no combinational path from resp_rdy or req_val.
  - resp_val/resp_* must stay stable while resp_val & !resp_rdy.
- Addressing: word index = addr[p_idx_bits+1:2]. Bits [1:0] and bits above the index are ignored, so out-of-range addresses wrap modulo the memory size.
- Memory access at accept:
  - Read: the word is sampled in the accept cycle, using state before any same-cycle write.
  - Write: the word updates at the accept edge.
  - Reads and writes are therefore strictly in program order. A read accepted the cycle after a write to the same word returns the new data.
- Backdoor: if init_en, mem[init idx] <= init_data.
  - If a write request fires the same cycle to the same word, init wins.
  - A same-cycle read returns the pre-edge value.
  - init_en is ignored during reset.
- Latency pipeline: p_latency-1 register stages (valid, op, opaque, addr, data), then a p_depth-entry FIFO whose head drives resp_*.
  - A request accepted at edge T has its response visible at cycle T+p_latency at the earliest: resp_val high in the cycle after edge T+p_latency-1.
  - Pipeline stages never stall, because the credit guarantees FIFO space.
- count register:
  - +1 on request fire, −1 on response fire; both in the same cycle leaves it unchanged.
  - Width is $clog2(p_depth+1).
- Throughput: with p_depth ≥ p_latency+1 and resp_rdy held high, one request is accepted every cycle.
- Responses return strictly in accept order. Opaque, op and addr are echoed unmodified.
- FIFO:
  - Circular, with pointer wrap at p_depth (non-power-of-2 depths supported by explicit wrap compare).
  - Simultaneous enqueue and dequeue at full or empty must be handled correctly (empty with enqueue plus dequeue is not possible, because of the latency stage).
- No X on resp_* when resp_val = 0: these outputs drive 0.

Test Plan:
- Reset, then preload via init mem[4] = 0xDEADBEEF; read addr 0x10, opaque 0x3A → resp at accept+2: op 0, opaque 0x3A, addr 0x10, data 0xDEADBEEF.
- Write 0x12345678 to 0x20, then read 0x20 on the next cycle → responses in order: the write (data 0), then the read (data 0x12345678).
- resp_rdy = 0 with 6 back-to-back reads (p_depth = 4) → exactly 4 accepted, req_rdy = 0 after the 4th. With resp_rdy = 1, the 4 responses drain in order and req_rdy returns high.
- resp_rdy = 1 with 10 back-to-back reads, p_latency = 2, p_depth = 4 → one accept per cycle, one response per cycle, 10 responses with opaque 0..9 in order.
- Address 0x400 with p_mem_words = 256 → aliases word 0. Same-cycle init_en and write request to word 0 → the init value persists.
- rst low for 1 cycle with 3 requests outstanding → resp_val = 0, req_rdy = 1 afterward. Accepted writes are still readable.
